// File: rtl/y86_mem_pkg.sv
// Shared types and constants for the Y86 byte-memory arbiter slice.
package y86_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    localparam int MAX_IF_BYTES = 10;
    localparam int DATA_BYTES   = 8;

    // True when any byte of [addr, addr+len-1] lies outside a 2**aw byte memory.
    function automatic logic range_bad(input logic [63:0] addr,
                                       input logic [3:0]  len,
                                       input int unsigned aw);
        logic [63:0] last_byte;
        last_byte = addr + 64'(len) - 64'd1;
        return ((addr >> aw) != 64'd0) || ((last_byte >> aw) != 64'd0);
    endfunction

endpackage

// File: rtl/y86_mem_arbiter_if.sv
// Request/response and memory-port bundle of the Y86 byte-memory arbiter.
interface y86_mem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              if_req;
    logic              if_rdy;
    logic [63:0]       if_addr;
    logic [3:0]        if_len;
    logic [79:0]       if_rdata;
    logic              if_done;
    logic              if_err;

    logic              d_req;
    logic              d_rdy;
    logic              d_we;
    logic [63:0]       d_addr;
    logic [63:0]       d_wdata;
    logic [63:0]       d_rdata;
    logic              d_done;
    logic              d_err;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, if_len,
        output if_rdy, if_rdata, if_done, if_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdy, d_rdata, d_done, d_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Requesters plus memory side.
    modport master (
        output if_req, if_addr, if_len,
        input  if_rdy, if_rdata, if_done, if_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdy, d_rdata, d_done, d_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/y86_mem_burst.sv
// Byte sequencer for one burst: byte counter, address/write-byte generation,
// and little-endian assembly of read bytes returned one cycle after issue.
module y86_mem_burst
    import y86_mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [63:0]                 start_addr,
    input  logic [3:0]                  start_len,
    input  logic                        start_we,
    input  logic [63:0]                 start_wdata,
    input  logic                        issue,
    output logic                        last,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [7:0]                  mem_wdata,
    input  logic [7:0]                  mem_rdata,
    output logic [8*MAX_IF_BYTES-1:0]   asm_data
);

    logic [63:0]               addr_q;
    logic [3:0]                len_q;
    logic                      we_q;
    logic [63:0]               wdata_q;
    logic [3:0]                k_q;
    logic [63:0]               byte_addr_p0;
    logic                      cap_vld_p1;
    logic [3:0]                cap_slot_p1;
    logic [8*MAX_IF_BYTES-1:0] asm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= 4'd0;
            cap_vld_p1 <= 1'b0;
        end else begin
            if (start) begin
                k_q <= 4'd0;
            end else if (issue) begin
                k_q <= k_q + 4'd1;
            end
            cap_vld_p1 <= issue && !we_q;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            addr_q  <= start_addr;
            len_q   <= start_len;
            we_q    <= start_we;
            wdata_q <= start_wdata;
            asm_q   <= '0;
        end else begin
            asm_q   <= asm_data;
        end
        cap_slot_p1 <= k_q;
    end

    // p0: byte issue; address arithmetic is full width, only the LSBs reach memory
    always_comb begin
        byte_addr_p0 = addr_q + {60'd0, k_q};
        mem_addr     = issue ? byte_addr_p0[ADDR_W-1:0] : '0;
        mem_wdata    = (issue && we_q) ? wdata_q[{k_q[2:0], 3'b000} +: 8] : 8'd0;
        last         = (k_q == len_q - 4'd1);
    end

    // p1: returned byte merged into its slot; the merged view is visible the same cycle
    always_comb begin
        asm_data = asm_q;
        if (cap_vld_p1) begin
            asm_data[{cap_slot_p1, 3'b000} +: 8] = mem_rdata;
        end
    end

endmodule

// File: rtl/y86_mem_arbiter.sv
// Fetch/data arbiter over one byte-wide synchronous memory.
// Define Y86_ARB_RANGE_CHK_EN to fail bursts that leave the 2**ADDR_W byte space.
module y86_mem_arbiter
    import y86_mem_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int MAX_IF_LEN = MAX_IF_BYTES
) (
    input logic              clk,
    input logic              rst_n,
    y86_mem_arbiter_if.slave bus
);

    arb_state_e                state_q, state_d;
    req_id_e                   owner_q, last_grant_q;
    logic                      err_q;
    logic                      we_q;

    logic                      idle;
    logic                      grant_if, grant_d, accept;
    logic [63:0]               start_addr;
    logic [3:0]                start_len;
    logic                      start_we;
    logic                      len_bad, rng_bad, start_err;
    logic                      issue, burst_last;
    logic [ADDR_W-1:0]         mem_addr;
    logic [7:0]                mem_wdata;
    logic [8*MAX_IF_BYTES-1:0] asm_data;

    logic [79:0]               if_rdata_q;
    logic                      if_err_q;
    logic [63:0]               d_rdata_q;
    logic                      d_err_q;

    // A tie goes to whichever requester did not win last time.
    always_comb begin
        idle       = (state_q == IDLE);
        grant_if   = idle && bus.if_req && (!bus.d_req || last_grant_q == REQ_D);
        grant_d    = idle && bus.d_req && (!bus.if_req || last_grant_q == REQ_IF);
        accept     = grant_if || grant_d;
        start_addr = grant_if ? bus.if_addr : bus.d_addr;
        start_len  = grant_if ? bus.if_len : 4'(DATA_BYTES);
        start_we   = grant_d && bus.d_we;
        len_bad    = grant_if && (bus.if_len == 4'd0 || int'(bus.if_len) > MAX_IF_LEN);
`ifdef Y86_ARB_RANGE_CHK_EN
        rng_bad    = accept && !len_bad && range_bad(start_addr, start_len, ADDR_W);
`else
        rng_bad    = 1'b0;
`endif
        start_err  = len_bad || rng_bad;
    end

    // Failed bursts still spend one cycle in DRAIN so done lands at accept+2.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = start_err ? DRAIN : ISSUE;
            ISSUE:   if (burst_last) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= REQ_IF;
            last_grant_q <= REQ_D;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= grant_if ? REQ_IF : REQ_D;
                last_grant_q <= grant_if ? REQ_IF : REQ_D;
                err_q        <= start_err;
                we_q         <= start_we;
            end
        end
    end

    // Results are latched as DRAIN ends (last read byte included) and held
    // until the same requester is accepted again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            if_err_q   <= 1'b0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
        end else begin
            if (grant_if) begin
                if_rdata_q <= '0;
                if_err_q   <= 1'b0;
            end
            if (grant_d) begin
                d_rdata_q <= '0;
                d_err_q   <= 1'b0;
            end
            if (state_q == DRAIN) begin
                if (owner_q == REQ_IF) begin
                    if_rdata_q <= err_q ? '0 : asm_data;
                    if_err_q   <= err_q;
                end else begin
                    d_rdata_q <= (err_q || we_q) ? '0 : asm_data[63:0];
                    d_err_q   <= err_q;
                end
            end
        end
    end

    assign issue = (state_q == ISSUE);

    y86_mem_burst #(
        .ADDR_W (ADDR_W)
    ) u_burst (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (accept),
        .start_addr  (start_addr),
        .start_len   (start_len),
        .start_we    (start_we),
        .start_wdata (bus.d_wdata),
        .issue       (issue),
        .last        (burst_last),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (bus.mem_rdata),
        .asm_data    (asm_data)
    );

    assign bus.if_rdy    = grant_if;
    assign bus.d_rdy     = grant_d;
    assign bus.if_done   = (state_q == DONE) && (owner_q == REQ_IF);
    assign bus.d_done    = (state_q == DONE) && (owner_q == REQ_D);
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_err    = if_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_err     = d_err_q;
    assign bus.mem_en    = issue;
    assign bus.mem_we    = issue && we_q;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;

endmodule
